// File: rtl/nv_nvdla_cacc_reg_pkg.sv
// Shared definitions for the CACC multi-group register bank: offsets, group state, field layout.
package nv_nvdla_cacc_reg_pkg;

    localparam logic [11:0] OFF_S_STATUS    = 12'h000;
    localparam logic [11:0] OFF_S_POINTER   = 12'h004;
    localparam logic [11:0] OFF_OP_ENABLE   = 12'h008;
    localparam logic [11:0] OFF_MISC        = 12'h00c;
    localparam logic [11:0] OFF_SIZE0       = 12'h010;
    localparam logic [11:0] OFF_CHANNEL     = 12'h014;
    localparam logic [11:0] OFF_ADDR        = 12'h018;
    localparam logic [11:0] OFF_BATCHES     = 12'h01c;
    localparam logic [11:0] OFF_LINE_STRIDE = 12'h020;
    localparam logic [11:0] OFF_SURF_STRIDE = 12'h024;
    localparam logic [11:0] OFF_MAP         = 12'h028;
    localparam logic [11:0] OFF_CLIP        = 12'h02c;
    localparam logic [11:0] OFF_SAT_COUNT   = 12'h030;
    localparam logic [11:0] OFF_CYA         = 12'h034;

    localparam int unsigned DIM_W    = 13;
    localparam int unsigned ADDR_W   = 27;
    localparam int unsigned STRIDE_W = 19;
    localparam int unsigned BATCH_W  = 5;
    localparam int unsigned CLIP_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PENDING = 2'd2
    } grp_state_t;

    typedef struct packed {
        logic                conv_mode;
        logic [1:0]          proc_precision;
        logic [DIM_W-1:0]    width;
        logic [DIM_W-1:0]    height;
        logic [DIM_W-1:0]    channel;
        logic [ADDR_W-1:0]   addr;
        logic [BATCH_W-1:0]  batches;
        logic [STRIDE_W-1:0] line_stride;
        logic [STRIDE_W-1:0] surf_stride;
        logic                line_packed;
        logic                surf_packed;
        logic [CLIP_W-1:0]   clip;
        logic [31:0]         cya;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        conv_mode:      1'b0,
        proc_precision: 2'b01,
        width:          '0,
        height:         '0,
        channel:        '0,
        addr:           '0,
        batches:        '0,
        line_stride:    '0,
        surf_stride:    '0,
        line_packed:    1'b0,
        surf_packed:    1'b0,
        clip:           '0,
        cya:            '0
    };

endpackage

// File: rtl/nv_nvdla_cacc_reg_group.sv
// One CACC register group: field flops with lock-gated write decode, readback, and
// the saturation counter enabled by NVDLA_CACC_REG_SAT_CNT_EN.
module nv_nvdla_cacc_reg_group
    import nv_nvdla_cacc_reg_pkg::*;
#(
    parameter int unsigned SAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [11:0]      offset,
    input  logic [31:0]      wr_data,
    input  logic             start,
    input  logic             running,
    input  logic [SAT_W-1:0] sat_inc,
    output cfg_t             cfg,
    output logic [31:0]      rd_data
);

    logic [31:0] sat_count;

    // wr_en already excludes writes to a busy group
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg <= CFG_RESET;
        end else if (wr_en) begin
            case (offset)
                OFF_MISC: begin
                    cfg.conv_mode      <= wr_data[0];
                    cfg.proc_precision <= wr_data[13:12];
                end
                OFF_SIZE0: begin
                    cfg.width  <= wr_data[12:0];
                    cfg.height <= wr_data[28:16];
                end
                OFF_CHANNEL:     cfg.channel     <= wr_data[12:0];
                OFF_ADDR:        cfg.addr        <= wr_data[31:5];
                OFF_BATCHES:     cfg.batches     <= wr_data[4:0];
                OFF_LINE_STRIDE: cfg.line_stride <= wr_data[23:5];
                OFF_SURF_STRIDE: cfg.surf_stride <= wr_data[23:5];
                OFF_MAP: begin
                    cfg.line_packed <= wr_data[0];
                    cfg.surf_packed <= wr_data[16];
                end
                OFF_CLIP:        cfg.clip        <= wr_data[4:0];
                OFF_CYA:         cfg.cya         <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef NVDLA_CACC_REG_SAT_CNT_EN
    logic [32:0] sat_sum;

    assign sat_sum = {1'b0, sat_count} + 33'(sat_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (start) begin
            sat_count <= '0;
        end else if (running) begin
            sat_count <= sat_sum[32] ? '1 : sat_sum[31:0];
        end
    end
`else
    logic unused_sat;

    assign sat_count  = '0;
    assign unused_sat = ^{start, running, sat_inc};
`endif

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_MISC: begin
                rd_data[0]     = cfg.conv_mode;
                rd_data[13:12] = cfg.proc_precision;
            end
            OFF_SIZE0: begin
                rd_data[12:0]  = cfg.width;
                rd_data[28:16] = cfg.height;
            end
            OFF_CHANNEL:     rd_data[12:0] = cfg.channel;
            OFF_ADDR:        rd_data[31:5] = cfg.addr;
            OFF_BATCHES:     rd_data[4:0]  = cfg.batches;
            OFF_LINE_STRIDE: rd_data[23:5] = cfg.line_stride;
            OFF_SURF_STRIDE: rd_data[23:5] = cfg.surf_stride;
            OFF_MAP: begin
                rd_data[0]  = cfg.line_packed;
                rd_data[16] = cfg.surf_packed;
            end
            OFF_CLIP:        rd_data[4:0]  = cfg.clip;
            OFF_SAT_COUNT:   rd_data       = sat_count;
            OFF_CYA:         rd_data       = cfg.cya;
            default: ;
        endcase
    end

endmodule

// File: rtl/nv_nvdla_cacc_reg_bank.sv
// CACC multi-group register bank: per-group op-enable FSMs, producer/consumer pointers,
// read and cfg muxes. Optional saturation counters: NVDLA_CACC_REG_SAT_CNT_EN.
module nv_nvdla_cacc_reg_bank
    import nv_nvdla_cacc_reg_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = 2,
    parameter int unsigned PTR_W      = $clog2(NUM_GROUPS),
    parameter int unsigned SAT_W      = 8
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic [11:0]           reg_offset,
    input  logic [31:0]           reg_wr_data,
    input  logic                  reg_wr_en,
    output logic [31:0]           reg_rd_data,
    input  logic                  dp_done,
    input  logic [SAT_W-1:0]      sat_inc,
    output logic                  dp_op_en,
    output logic [PTR_W-1:0]      consumer_ptr,
    output logic [PTR_W-1:0]      producer_ptr,
    output logic [NUM_GROUPS-1:0] done_intr,
    output logic [4:0]            cfg_batches,
    output logic [4:0]            cfg_clip_truncate,
    output logic [26:0]           cfg_dataout_addr,
    output logic                  cfg_line_packed,
    output logic                  cfg_surf_packed,
    output logic [12:0]           cfg_dataout_width,
    output logic [12:0]           cfg_dataout_height,
    output logic [12:0]           cfg_dataout_channel,
    output logic [18:0]           cfg_line_stride,
    output logic [18:0]           cfg_surf_stride,
    output logic                  cfg_conv_mode,
    output logic [1:0]            cfg_proc_precision,
    output logic [31:0]           cfg_cya
);

    grp_state_t            state_q [NUM_GROUPS];
    grp_state_t            state_d [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] start;
    logic [NUM_GROUPS-1:0] grp_wr;
    logic [PTR_W-1:0]      consumer_d;
    logic [NUM_GROUPS-1:0] done_d;
    logic                  dp_op_en_d;
    logic                  done_fire;
    logic                  op_wr;
    cfg_t                  cfg_arr [NUM_GROUPS];
    logic [31:0]           grp_rd  [NUM_GROUPS];
    cfg_t                  cfg_sel;

    // PENDING->RUNNING is qualified by the registered consumer_ptr, which yields
    // the one-cycle bubble after dp_done without extra state.
    always_comb begin
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            state_d[g] = state_q[g];
        end
        start      = '0;
        done_d     = '0;
        consumer_d = consumer_ptr;
        done_fire  = dp_done && (state_q[consumer_ptr] == ST_RUNNING);
        op_wr      = reg_wr_en && (reg_offset == OFF_OP_ENABLE) && reg_wr_data[0];

        if (done_fire) begin
            state_d[consumer_ptr] = ST_IDLE;
            consumer_d            = consumer_ptr + PTR_W'(1);
            done_d[consumer_ptr]  = 1'b1;
        end

        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            if (op_wr && (producer_ptr == PTR_W'(g)) && (state_q[g] == ST_IDLE)) begin
                state_d[g] = (PTR_W'(g) == consumer_ptr) ? ST_RUNNING : ST_PENDING;
                start[g]   = 1'b1;
            end else if ((state_q[g] == ST_PENDING) && (PTR_W'(g) == consumer_ptr)) begin
                state_d[g] = ST_RUNNING;
            end
        end

        dp_op_en_d = (state_d[consumer_d] == ST_RUNNING);
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                state_q[g] <= ST_IDLE;
            end
            consumer_ptr <= '0;
            producer_ptr <= '0;
            done_intr    <= '0;
            dp_op_en     <= 1'b0;
        end else begin
            for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                state_q[g] <= state_d[g];
            end
            consumer_ptr <= consumer_d;
            done_intr    <= done_d;
            dp_op_en     <= dp_op_en_d;
            if (reg_wr_en && (reg_offset == OFF_S_POINTER)) begin
                producer_ptr <= reg_wr_data[PTR_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        assign grp_wr[g] = reg_wr_en && (producer_ptr == PTR_W'(g)) && (state_q[g] == ST_IDLE);

        nv_nvdla_cacc_reg_group #(
            .SAT_W(SAT_W)
        ) u_group (
            .clk     (nvdla_core_clk),
            .rst     (nvdla_core_rst),
            .wr_en   (grp_wr[g]),
            .offset  (reg_offset),
            .wr_data (reg_wr_data),
            .start   (start[g]),
            .running (state_q[g] == ST_RUNNING),
            .sat_inc (sat_inc),
            .cfg     (cfg_arr[g]),
            .rd_data (grp_rd[g])
        );
    end

    always_comb begin
        reg_rd_data = '0;
        case (reg_offset)
            OFF_S_STATUS: begin
                for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                    reg_rd_data[2*g +: 2] = state_q[g];
                end
            end
            OFF_S_POINTER: begin
                reg_rd_data[PTR_W-1:0]  = producer_ptr;
                reg_rd_data[16 +: PTR_W] = consumer_ptr;
            end
            OFF_OP_ENABLE: reg_rd_data[0] = (state_q[producer_ptr] != ST_IDLE);
            default:       reg_rd_data = grp_rd[producer_ptr];
        endcase
    end

    assign cfg_sel             = cfg_arr[consumer_ptr];
    assign cfg_batches         = cfg_sel.batches;
    assign cfg_clip_truncate   = cfg_sel.clip;
    assign cfg_dataout_addr    = cfg_sel.addr;
    assign cfg_line_packed     = cfg_sel.line_packed;
    assign cfg_surf_packed     = cfg_sel.surf_packed;
    assign cfg_dataout_width   = cfg_sel.width;
    assign cfg_dataout_height  = cfg_sel.height;
    assign cfg_dataout_channel = cfg_sel.channel;
    assign cfg_line_stride     = cfg_sel.line_stride;
    assign cfg_surf_stride     = cfg_sel.surf_stride;
    assign cfg_conv_mode       = cfg_sel.conv_mode;
    assign cfg_proc_precision  = cfg_sel.proc_precision;
    assign cfg_cya             = cfg_sel.cya;

endmodule

// File: tb/tb_nv_nvdla_cacc_reg_bank.sv
// Randomised self-checking bench for nv_nvdla_cacc_reg_bank against a register-image model.
module tb_nv_nvdla_cacc_reg_bank;

    localparam int NG = 4;
    localparam int PW = 2;
    localparam int SW = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PEND = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   reg_offset;
    logic [31:0]   reg_wr_data;
    logic          reg_wr_en;
    logic [31:0]   reg_rd_data;
    logic          dp_done;
    logic [SW-1:0] sat_inc;
    logic          dp_op_en;
    logic [PW-1:0] consumer_ptr;
    logic [PW-1:0] producer_ptr;
    logic [NG-1:0] done_intr;
    logic [4:0]    cfg_batches, cfg_clip_truncate;
    logic [26:0]   cfg_dataout_addr;
    logic          cfg_line_packed, cfg_surf_packed, cfg_conv_mode;
    logic [12:0]   cfg_dataout_width, cfg_dataout_height, cfg_dataout_channel;
    logic [18:0]   cfg_line_stride, cfg_surf_stride;
    logic [1:0]    cfg_proc_precision;
    logic [31:0]   cfg_cya;

    always #5 clk = ~clk;

    nv_nvdla_cacc_reg_bank #(
        .NUM_GROUPS(NG),
        .SAT_W(SW)
    ) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rst     (rst),
        .reg_offset         (reg_offset),
        .reg_wr_data        (reg_wr_data),
        .reg_wr_en          (reg_wr_en),
        .reg_rd_data        (reg_rd_data),
        .dp_done            (dp_done),
        .sat_inc            (sat_inc),
        .dp_op_en           (dp_op_en),
        .consumer_ptr       (consumer_ptr),
        .producer_ptr       (producer_ptr),
        .done_intr          (done_intr),
        .cfg_batches        (cfg_batches),
        .cfg_clip_truncate  (cfg_clip_truncate),
        .cfg_dataout_addr   (cfg_dataout_addr),
        .cfg_line_packed    (cfg_line_packed),
        .cfg_surf_packed    (cfg_surf_packed),
        .cfg_dataout_width  (cfg_dataout_width),
        .cfg_dataout_height (cfg_dataout_height),
        .cfg_dataout_channel(cfg_dataout_channel),
        .cfg_line_stride    (cfg_line_stride),
        .cfg_surf_stride    (cfg_surf_stride),
        .cfg_conv_mode      (cfg_conv_mode),
        .cfg_proc_precision (cfg_proc_precision),
        .cfg_cya            (cfg_cya)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: each group is a readback image indexed by word offset, plus a state and counter.
    int          st   [NG];
    int          prod, cons;
    logic [31:0] img  [NG][16];
    logic [31:0] sat  [NG];
    logic [NG-1:0] intr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int idx);
        case (idx)
            3:       return 32'h0000_3001;
            4:       return 32'h1FFF_1FFF;
            5:       return 32'h0000_1FFF;
            6:       return 32'hFFFF_FFE0;
            7:       return 32'h0000_001F;
            8, 9:    return 32'h00FF_FFE0;
            10:      return 32'h0001_0001;
            11:      return 32'h0000_001F;
            13:      return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        prod = 0;
        cons = 0;
        intr = '0;
        for (int g = 0; g < NG; g++) begin
            st[g]  = M_IDLE;
            sat[g] = '0;
            for (int i = 0; i < 16; i++) img[g][i] = '0;
            img[g][3] = 32'h0000_1000;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] off);
        logic [31:0] r;
        int idx;
        r   = '0;
        idx = int'(off) / 4;
        if (off == 12'h000) begin
            for (int g = 0; g < NG; g++) r = r | (32'(st[g]) << (2 * g));
        end else if (off == 12'h004) begin
            r = 32'(prod) | (32'(cons) << 16);
        end else if (off == 12'h008) begin
            r = (st[prod] != M_IDLE) ? 32'd1 : 32'd0;
        end else if (off == 12'h030) begin
            r = sat[prod];
        end else if (off[1:0] == 2'b00 && wmask(idx) != 0) begin
            r = img[prod][idx];
        end
        return r;
    endfunction

    task automatic model_edge(input logic we, input logic [11:0] off, input logic [31:0] d,
                              input logic done, input logic [SW-1:0] si);
        int nst[NG];
        int oc;
        int idx;
        longint unsigned s;
        oc   = cons;
        idx  = int'(off) / 4;
        intr = '0;
        for (int g = 0; g < NG; g++) nst[g] = st[g];
        if (done && st[oc] == M_RUN) begin
            nst[oc]  = M_IDLE;
            cons     = (oc + 1) % NG;
            intr[oc] = 1'b1;
        end
        for (int g = 0; g < NG; g++) begin
            if (st[g] == M_PEND && g == oc) nst[g] = M_RUN;
`ifdef NVDLA_CACC_REG_SAT_CNT_EN
            if (st[g] == M_RUN) begin
                s = longint'(sat[g]) + longint'(si);
                sat[g] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            end
`endif
        end
        if (we) begin
            if (off == 12'h008 && d[0] && st[prod] == M_IDLE) begin
                nst[prod] = (prod == oc) ? M_RUN : M_PEND;
                sat[prod] = '0;
            end
            if (off[1:0] == 2'b00 && wmask(idx) != 0 && st[prod] == M_IDLE)
                img[prod][idx] = d & wmask(idx);
        end
        for (int g = 0; g < NG; g++) st[g] = nst[g];
        if (we && off == 12'h004) prod = int'(d % NG);
    endtask

    task automatic check_outputs();
        check("dp_op_en", 32'(dp_op_en), (st[cons] == M_RUN) ? 32'd1 : 32'd0);
        check("consumer_ptr", 32'(consumer_ptr), 32'(cons));
        check("producer_ptr", 32'(producer_ptr), 32'(prod));
        check("done_intr", 32'(done_intr), 32'(intr));
        check("cfg_conv_mode", 32'(cfg_conv_mode), 32'(img[cons][3][0]));
        check("cfg_proc_precision", 32'(cfg_proc_precision), 32'(img[cons][3][13:12]));
        check("cfg_width", 32'(cfg_dataout_width), 32'(img[cons][4][12:0]));
        check("cfg_height", 32'(cfg_dataout_height), 32'(img[cons][4][28:16]));
        check("cfg_channel", 32'(cfg_dataout_channel), 32'(img[cons][5][12:0]));
        check("cfg_addr", 32'(cfg_dataout_addr), 32'(img[cons][6][31:5]));
        check("cfg_batches", 32'(cfg_batches), 32'(img[cons][7][4:0]));
        check("cfg_line_stride", 32'(cfg_line_stride), 32'(img[cons][8][23:5]));
        check("cfg_surf_stride", 32'(cfg_surf_stride), 32'(img[cons][9][23:5]));
        check("cfg_line_packed", 32'(cfg_line_packed), 32'(img[cons][10][0]));
        check("cfg_surf_packed", 32'(cfg_surf_packed), 32'(img[cons][10][16]));
        check("cfg_clip", 32'(cfg_clip_truncate), 32'(img[cons][11][4:0]));
        check("cfg_cya", cfg_cya, img[cons][13]);
    endtask

    task automatic cycle(input logic we, input logic [11:0] off, input logic [31:0] d,
                         input logic done, input logic [SW-1:0] si);
        @(negedge clk);
        reg_wr_en   = we;
        reg_offset  = off;
        reg_wr_data = d;
        dp_done     = done;
        sat_inc     = si;
        #1 check("rd_data", reg_rd_data, model_read(off));
        @(posedge clk);
        model_edge(we, off, d, done, si);
        #1 check_outputs();
    endtask

    // Combinational read between the sampling point and the next driving negedge.
    task automatic peek(input string tag, input logic [11:0] off, input logic [31:0] exp);
        reg_wr_en  = 1'b0;
        dp_done    = 1'b0;
        reg_offset = off;
        #1 check(tag, reg_rd_data, exp);
        check({tag, "_model"}, reg_rd_data, model_read(off));
    endtask

    logic [11:0] offs [18] = '{12'h000, 12'h004, 12'h008, 12'h00c, 12'h010, 12'h014,
                               12'h018, 12'h01c, 12'h020, 12'h024, 12'h028, 12'h02c,
                               12'h030, 12'h034, 12'h038, 12'h100, 12'h00e, 12'hffc};

    initial begin
        logic [31:0] sat_exp;
        int r;
        rst         = 1'b1;
        reg_wr_en   = 1'b0;
        reg_offset  = '0;
        reg_wr_data = '0;
        dp_done     = 1'b0;
        sat_inc     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset values
        peek("rst_misc", 12'h00c, 32'h0000_1000);
        peek("rst_status", 12'h000, 32'h0);
        check("rst_dp_op_en", 32'(dp_op_en), 32'd0);

        // group0 program and start
        cycle(1'b1, 12'h010, 32'h20, 1'b0, '0);
        cycle(1'b1, 12'h008, 32'h1, 1'b0, '0);
        check("g0_op_en", 32'(dp_op_en), 32'd1);
        check("g0_width", 32'(cfg_dataout_width), 32'h20);
        peek("g0_status", 12'h000, 32'h1);

        // queue group1 behind running group0
        cycle(1'b1, 12'h004, 32'h1, 1'b0, '0);
        cycle(1'b1, 12'h010, 32'h77, 1'b0, '0);
        cycle(1'b1, 12'h008, 32'h1, 1'b0, '0);
        peek("g1_pending_status", 12'h000, 32'h9);

        cycle(1'b0, 12'h000, 32'h0, 1'b1, '0);
        check("done_intr_g0", 32'(done_intr), 32'h1);
        check("bubble_op_en", 32'(dp_op_en), 32'd0);
        check("bubble_width", 32'(cfg_dataout_width), 32'h77);
        cycle(1'b0, 12'h000, 32'h0, 1'b0, '0);
        check("g1_op_en", 32'(dp_op_en), 32'd1);
        check("g1_intr_clear", 32'(done_intr), 32'h0);

        // locked write to running group1
        cycle(1'b1, 12'h010, 32'h55, 1'b0, '0);
        peek("lock_width", 12'h010, 32'h77);

        // saturation accumulation
        repeat (4) cycle(1'b0, 12'h030, 32'h0, 1'b0, SW'(3));
`ifdef NVDLA_CACC_REG_SAT_CNT_EN
        sat_exp = 32'd12;
`else
        sat_exp = 32'd0;
`endif
        peek("sat_count", 12'h030, sat_exp);

        cycle(1'b0, 12'h000, 32'h0, 1'b1, '0);
        check("done_intr_g1", 32'(done_intr), 32'h2);

        // randomised traffic
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)
                cycle(1'b1, 12'h008, ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0,
                      $urandom_range(0, 4) == 0, SW'($urandom));
            else if (r == 3)
                cycle(1'b1, 12'h004, $urandom, $urandom_range(0, 4) == 0, SW'($urandom));
            else if (r <= 6)
                cycle(1'b1, offs[$urandom_range(0, 17)], $urandom,
                      $urandom_range(0, 4) == 0, SW'($urandom));
            else
                cycle(1'b0, offs[$urandom_range(0, 17)], $urandom,
                      $urandom_range(0, 4) == 0, SW'($urandom));
        end

        // get the consumer group running, then reset asynchronously mid-cycle
        cycle(1'b1, 12'h004, 32'(cons), 1'b0, '0);
        cycle(1'b1, 12'h008, 32'h1, 1'b0, '0);
        cycle(1'b0, 12'h000, 32'h0, 1'b0, '0);
        check("pre_reset_op_en", 32'(dp_op_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_op_en", 32'(dp_op_en), 32'd0);
        check("arst_consumer", 32'(consumer_ptr), 32'd0);
        check("arst_producer", 32'(producer_ptr), 32'd0);
        check("arst_intr", 32'(done_intr), 32'd0);
        check("arst_precision", 32'(cfg_proc_precision), 32'd1);
        peek("arst_status", 12'h000, 32'h0);
        peek("arst_misc", 12'h00c, 32'h0000_1000);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 12'h004, 32'h0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
